// File: rtl/mul_pipe.sv
// mul_pipe: STAGES-deep pipelined signed multiplier with stall, flush, busy and overflow.
// Define MUL_UNSIGNED_EN to add a per-op is_unsigned input carried down the pipe.
module mul_pipe #(
    parameter int DATA_W = 32,
    parameter int DST_W  = 5,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DST_W-1:0]  in_dst,
`ifdef MUL_UNSIGNED_EN
    input  logic              is_unsigned,
`endif
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic [DST_W-1:0]  dst,
    output logic              busy
);
    localparam int N = STAGES - 1;

    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $error("mul_pipe: STAGES must be within 2..8");
    end

    logic [N-1:0]          v;
    logic [N-1:0]          u;
    logic [2*DATA_W-1:0]   p [N];
    logic [DST_W-1:0]      d [N];
    logic                  sx;
    logic [2*DATA_W-1:0]   prod_in;
    logic [2*DATA_W-1:0]   pf;
    logic                  ovf;

`ifdef MUL_UNSIGNED_EN
    assign sx = ~is_unsigned;
`else
    assign sx = 1'b1;
`endif

    // Extending to 2*DATA_W and keeping the low half yields the exact signed or unsigned product.
    assign prod_in = {{DATA_W{sx & a[DATA_W-1]}}, a} * {{DATA_W{sx & b[DATA_W-1]}}, b};
    assign pf      = p[N-1];
    assign ovf     = u[N-1] ? |pf[2*DATA_W-1:DATA_W]
                            : pf[2*DATA_W-1:DATA_W] != {DATA_W{pf[DATA_W-1]}};
    assign busy    = |v | out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v         <= '0;
            u         <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            dst       <= '0;
            for (int i = 0; i < N; i++) begin
                p[i] <= '0;
                d[i] <= '0;
            end
        end else if (flush) begin
            v         <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            v[0] <= in_valid;
            u[0] <= ~sx;
            p[0] <= prod_in;
            d[0] <= in_dst;
            for (int i = 1; i < N; i++) begin
                v[i] <= v[i-1];
                u[i] <= u[i-1];
                p[i] <= p[i-1];
                d[i] <= d[i-1];
            end
            out_valid <= v[N-1];
            result    <= pf[DATA_W-1:0];
            zero      <= pf[DATA_W-1:0] == '0;
            overflow  <= ovf;
            dst       <= d[N-1];
        end
    end
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: random and directed stimulus checked against a queue-based reference model.
module tb_mul_pipe;
    localparam int STAGES = 4;

    logic        clk = 0, reset = 1, in_valid = 0, stall = 0, flush = 0, uns = 0;
    logic [31:0] a = 0, b = 0, result;
    logic [4:0]  in_dst = 0, dst;
    logic        out_valid, zero, overflow, busy;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [31:0] r;
        logic        z, o;
        logic [4:0]  d;
        int          left;
    } op_t;
    op_t q[$];

    mul_pipe #(.DATA_W(32), .DST_W(5), .STAGES(STAGES)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .in_dst(in_dst),
`ifdef MUL_UNSIGNED_EN
        .is_unsigned(uns),
`endif
        .stall(stall), .flush(flush), .out_valid(out_valid), .result(result),
        .zero(zero), .overflow(overflow), .dst(dst), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk(logic [31:0] x, logic [31:0] y, logic [4:0] t, logic un);
        op_t o;
        longint sp;
        longint unsigned up;
        if (un) begin
            up  = {32'b0, x} * {32'b0, y};
            o.r = up[31:0];
            o.o = up > 64'h0000_0000_FFFF_FFFF;
        end else begin
            sp  = longint'(signed'(x)) * longint'(signed'(y));
            o.r = sp[31:0];
            o.o = sp > 64'sd2147483647 || sp < -64'sd2147483648;
        end
        o.z    = o.r == 0;
        o.d    = t;
        o.left = STAGES - 1;
        return o;
    endfunction

    task automatic model_edge();
        if (reset || flush) q.delete();
        else if (!stall) begin
            if (q.size() > 0 && q[0].left == 0) void'(q.pop_front());
            foreach (q[i]) q[i].left--;
            if (in_valid) q.push_back(mk(a, b, in_dst, uns));
        end
    endtask

    task automatic check_out();
        logic ev;
        ev = q.size() > 0 && q[0].left == 0;
        chk("out_valid", out_valid, ev);
        chk("busy", busy, q.size() > 0);
        if (ev) begin
            chk("result", result, q[0].r);
            chk("zero", zero, q[0].z);
            chk("overflow", overflow, q[0].o);
            chk("dst", dst, q[0].d);
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_zero"}, zero, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_dst"}, dst, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_out();
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic op(logic [31:0] x, logic [31:0] y, logic [4:0] t);
        in_valid = 1; a = x; b = y; in_dst = t;
        tick();
        in_valid = 0;
    endtask

    initial begin
        #1;
        check_zero("reset_async");
        idle(2);
        check_zero("reset");
        reset = 0;
        uns = 0;
        op(3, 5, 7);
        idle(5);
        op(2, 2, 1);
        op(-4, 6, 2);
        op(0, 123, 3);
        idle(5);
        op(32'h4000_0000, 4, 4);
        op(-1, -1, 5);
        op(32'h8000_0000, -1, 6);
        op(32'h8000_0000, 1, 8);
        idle(5);
        op(10, 11, 9);
        idle(1);
        stall = 1;
        in_valid = 1; a = 99; b = 99; in_dst = 30;
        idle(3);
        stall = 0; in_valid = 0;
        idle(5);
        op(6, 7, 10);
        op(8, 9, 11);
        stall = 1; flush = 1;
        in_valid = 1; a = 1; b = 1; in_dst = 12;
        tick();
        chk("flush_busy", busy, 0);
        stall = 0; flush = 0; in_valid = 0;
        idle(5);
        op(1, 2, 13);
        op(3, 4, 14);
        op(5, 6, 15);
        @(posedge clk);
        #3 reset = 1;
        #1;
        check_zero("reset_mid");
        q.delete();
        idle(2);
        reset = 0;
        idle(6);
        op(7, 7, 16);
        idle(5);
        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            stall    = $urandom_range(0, 7) == 0;
            flush    = $urandom_range(0, 19) == 0;
            case ($urandom_range(0, 5))
                0: a = 0;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: a = $urandom_range(0, 255);
                default: a = $urandom;
            endcase
            b      = $urandom_range(0, 3) == 0 ? $urandom_range(0, 65535) : $urandom;
            in_dst = 5'($urandom);
`ifdef MUL_UNSIGNED_EN
            uns = 1'($urandom);
`endif
            tick();
        end
        in_valid = 0; stall = 0; flush = 0;
        idle(STAGES + 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
